sdio_rx: RTL and testbench
==========================

# sdio_rx

Receives SD-bus command-line responses (R1/R1b/R6/R7, R2, R3) following a command issued by `sdio_tx`. It is armed by the command controller when `sdio_tx` finishes driving a command. It samples `sdio_cmd_i` on rising edges of the divided `sdio_clk` produced by `sdio_clk_control`. It returns the parsed index and argument, or the 127-bit R2 payload, with CRC7, framing and timeout status.

## Interface

Reset and clocking (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.

Parameters:
- TIMEOUT_CYC, 255: number of `sdio_clk` rising edges to wait for a start bit before timeout (8-bit counter).

Ports:
- clk  in  1  system clock; all logic runs on this clock.
- rst_n  in  1  asynchronous active-low reset.
- sdio_clk  in  1  divided SD clock, a level sampled in the `clk` domain.
- sdio_cmd_i  in  1  CMD line input.
- i_en  in  1  one-`clk` arm pulse.
- i_resp_type  in  2  0 = 48-bit with CRC, 1 = R2 (136-bit), 2 = R3 (48-bit, no CRC check), 3 = treated as 0.
- o_busy  out  1  high from arm until done.
- o_done  out  1  one-`clk` completion pulse.
- o_resp_idx  out  6  response bits [45:40].
- o_resp_arg  out  32  response bits [39:8].
- o_resp_long  out  127  R2 bits [127:1].
- o_crc_err  out  1  CRC7 mismatch.
- o_frame_err  out  1  transmission bit ≠ 0 or end bit ≠ 1.
- o_timeout  out  1  no start bit within TIMEOUT_CYC edges.

## Operation

- Sample strobe: register `sdio_clk` into `sdio_clk_d`. `stb = sdio_clk & ~sdio_clk_d`. `sdio_cmd_i` is sampled in the `clk` cycle where `stb` = 1.
- FSM states and transitions:
  - IDLE → WAIT when `i_en` = 1. On this transition:
    - latch `i_resp_type` and compute the frame length L (48 or 136);
    - clear all status flags;
    - clear the timeout counter and bit counter.
  - `i_en` is ignored outside IDLE.
  - WAIT, on each `stb`:
    - if the sample is 0 → RECV with bit count = 1;
    - otherwise increment the timeout counter; when it reaches TIMEOUT_CYC, set `o_timeout` → DONE.
  - RECV, on each `stb`: shift the sample into a 136-bit register (MSB first) and increment the bit count. When count = L → DONE.
  - DONE: `o_done` = 1 for one cycle → IDLE.
- On entry to DONE after a full frame:
  - `o_frame_err` = (bit L−2 ≠ 0) | (bit 0 ≠ 1).
  - Type 0 or 3:
    - update `o_resp_idx` and `o_resp_arg`;
    - CRC7 (G = x⁷+x³+1, init 0) is computed serially over frame bits [47:8], start bit included;
    - `o_crc_err` = (CRC ≠ bits [7:1]).
  - Type 2: update `o_resp_idx` and `o_resp_arg`; `o_crc_err` = 0.
  - Type 1: update `o_resp_long` = bits [127:1]; `o_crc_err` = 0; `o_resp_idx` and `o_resp_arg` are unchanged.
- Outputs hold their values until the next arm. A timeout leaves the data outputs unchanged.
- `o_busy` = (state ≠ IDLE).
- Reset values: all outputs 0, FSM in IDLE, `sdio_clk_d` = 0, counters 0. Reset asserted mid-frame aborts immediately with no `o_done`.
- The block never drives the CMD line; line ownership belongs to `sdio_tx`.

## Timing

- `o_busy` rises the cycle after `i_en`.
- The first possible sample is the first `stb` at or after the cycle following `i_en`.
- `o_done` and the status outputs are valid in the cycle after the `stb` that captured bit L. `o_busy` falls one cycle after `o_done`.
- Timeout: `o_done` is asserted the cycle after the TIMEOUT_CYC-th high sample.
- An `i_en` in the same cycle as `o_done` is ignored; re-arm is allowed from the first IDLE cycle.
- CRC is updated per bit, so there is no extra latency beyond the single DONE cycle.

## Test plan

- R1 CMD17 response: arm with type 0 and drive the frame after 5 `sdio_clk` idle-high cycles. Frame: index 17, arg 0x00000900, CRC7 from the bench model, end bit 1. Required: `o_resp_idx` = 17, `o_resp_arg` = 0x00000900, all errors 0, exactly one `o_done`.
- Same frame with CRC bit 1 inverted → `o_crc_err` = 1, `o_frame_err` = 0, data still captured.
- R3, type 2: index field 0x3F, arg 0x80FF8000, CRC field 0x7F → `o_resp_arg` = 0x80FF8000, `o_crc_err` = 0.
- R2, type 1: 136-bit frame with payload bits [127:1] = an alternating 0xAA… pattern → `o_resp_long` matches, `o_resp_idx` and `o_resp_arg` unchanged from the previous response.
- Line held high, TIMEOUT_CYC = 8 → `o_timeout` = 1 and `o_done` one cycle after the 8th strobe; data unchanged.
- Framing and reset:
  - end bit driven 0 → `o_frame_err` = 1;
  - `rst_n` pulsed at bit 20 → all outputs 0, no `o_done`;
  - a subsequent arm works normally.

Source files
------------

// File: rtl/sdio_rx.sv
// ---------------------------------------------------------------------------
// sdio_rx
//
// Receiver for SD-bus command-line responses. Once armed by the command
// controller it waits for a start bit on the CMD line, shifts in a 48-bit
// (R1/R1b/R6/R7/R3) or 136-bit (R2) frame, and reports the parsed fields
// together with CRC7, framing and timeout status. The CMD line is only ever
// observed here; it is never driven.
//
// Ports:
//   clk          system clock, all logic runs on it
//   rst_n        asynchronous active-low reset
//   sdio_clk     divided SD clock, treated as a level in the clk domain
//   sdio_cmd_i   CMD line input
//   i_en         one-cycle arm pulse (ignored unless idle)
//   i_resp_type  0 = 48-bit with CRC, 1 = R2 136-bit, 2 = R3 no CRC, 3 = as 0
//   o_busy       high from the cycle after arm until after the done pulse
//   o_done       one-cycle completion pulse
//   o_resp_idx   response bits [45:40]
//   o_resp_arg   response bits [39:8]
//   o_resp_long  R2 bits [127:1]
//   o_crc_err    CRC7 mismatch
//   o_frame_err  transmission bit not 0 or end bit not 1
//   o_timeout    no start bit seen within TIMEOUT_CYC sdio_clk edges
// ---------------------------------------------------------------------------
module sdio_rx #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sdio_clk,
    input  logic         sdio_cmd_i,
    input  logic         i_en,
    input  logic [1:0]   i_resp_type,
    output logic         o_busy,
    output logic         o_done,
    output logic [5:0]   o_resp_idx,
    output logic [31:0]  o_resp_arg,
    output logic [126:0] o_resp_long,
    output logic         o_crc_err,
    output logic         o_frame_err,
    output logic         o_timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRecv,
        StDone
    } state_t;

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYC);

    state_t         state_q, state_d;
    logic           sdioClk_q;
    logic [1:0]     type_q, type_d;
    logic [7:0]     toCnt_q, toCnt_d;
    logic [7:0]     bitCnt_q, bitCnt_d;
    logic [134:0]   shreg_q, shreg_d;
    logic [6:0]     crc_q, crc_d;
    logic [5:0]     idx_q, idx_d;
    logic [31:0]    arg_q, arg_d;
    logic [126:0]   long_q, long_d;
    logic           crcErr_q, crcErr_d;
    logic           frameErr_q, frameErr_d;
    logic           timeout_q, timeout_d;

    logic           stb;
    logic           isLong;
    logic [7:0]     frameLen;
    logic [7:0]     toCntInc;
    logic [7:0]     bitCntInc;
    logic [135:0]   shregShift;
    logic           crcFb;
    logic [6:0]     crcStep;
    logic           frameBad;

    // Helper values shared by the FSM: the sample strobe on each rising
    // sdio_clk edge, the frame as it will look once the current sample is
    // shifted in, and one serial CRC7 step (x^7 + x^3 + 1) over that sample.
    // The register is one bit short of a full R2 frame because the oldest
    // bit is only needed on the very last shift, where shregShift supplies it.
    // The start-bit term in frameBad can never fire (RECV is only entered on
    // a 0 sample) but keeps the oldest stored bit meaningful.
    always_comb begin
        stb        = sdio_clk & ~sdioClk_q;
        isLong     = (type_q == 2'd1);
        frameLen   = isLong ? 8'd136 : 8'd48;
        toCntInc   = toCnt_q + 8'd1;
        bitCntInc  = bitCnt_q + 8'd1;
        shregShift = {shreg_q, sdio_cmd_i};
        crcFb      = sdio_cmd_i ^ crc_q[6];
        crcStep    = {crc_q[5:0], 1'b0} ^ (crcFb ? 7'h09 : 7'h00);
        if (isLong) begin
            frameBad = shregShift[135] | shregShift[134] | ~shregShift[0];
        end else begin
            frameBad = shregShift[47] | shregShift[46] | ~shregShift[0];
        end
    end

    // Next-state and result logic. Results are written on the transition
    // into DONE so they are already valid while o_done is high. A timeout
    // only raises its flag and leaves the data outputs untouched.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        toCnt_d    = toCnt_q;
        bitCnt_d   = bitCnt_q;
        shreg_d    = shreg_q;
        crc_d      = crc_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        long_d     = long_q;
        crcErr_d   = crcErr_q;
        frameErr_d = frameErr_q;
        timeout_d  = timeout_q;

        case (state_q)
            StIdle: begin
                if (i_en) begin
                    state_d    = StWait;
                    type_d     = i_resp_type;
                    toCnt_d    = 8'd0;
                    bitCnt_d   = 8'd0;
                    crc_d      = 7'd0;
                    crcErr_d   = 1'b0;
                    frameErr_d = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            StWait: begin
                if (stb) begin
                    if (!sdio_cmd_i) begin
                        state_d  = StRecv;
                        bitCnt_d = 8'd1;
                        shreg_d  = shregShift[134:0];
                        crc_d    = crcStep;
                    end else begin
                        toCnt_d = toCntInc;
                        if (toCntInc == TimeoutLimit) begin
                            timeout_d = 1'b1;
                            state_d   = StDone;
                        end
                    end
                end
            end
            StRecv: begin
                if (stb) begin
                    shreg_d  = shregShift[134:0];
                    bitCnt_d = bitCntInc;
                    if (bitCnt_q < 8'd40) begin
                        crc_d = crcStep;
                    end
                    if (bitCntInc == frameLen) begin
                        state_d    = StDone;
                        frameErr_d = frameBad;
                        if (isLong) begin
                            long_d   = shregShift[127:1];
                            crcErr_d = 1'b0;
                        end else begin
                            idx_d    = shregShift[45:40];
                            arg_d    = shregShift[39:8];
                            crcErr_d = (type_q != 2'd2) && (crc_q != shregShift[7:1]);
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset clears everything, aborting any
    // frame in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sdioClk_q  <= 1'b0;
            type_q     <= 2'd0;
            toCnt_q    <= 8'd0;
            bitCnt_q   <= 8'd0;
            shreg_q    <= '0;
            crc_q      <= 7'd0;
            idx_q      <= 6'd0;
            arg_q      <= 32'd0;
            long_q     <= '0;
            crcErr_q   <= 1'b0;
            frameErr_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sdioClk_q  <= sdio_clk;
            type_q     <= type_d;
            toCnt_q    <= toCnt_d;
            bitCnt_q   <= bitCnt_d;
            shreg_q    <= shreg_d;
            crc_q      <= crc_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            long_q     <= long_d;
            crcErr_q   <= crcErr_d;
            frameErr_q <= frameErr_d;
            timeout_q  <= timeout_d;
        end
    end

    // Output mapping.
    always_comb begin
        o_busy      = (state_q != StIdle);
        o_done      = (state_q == StDone);
        o_resp_idx  = idx_q;
        o_resp_arg  = arg_q;
        o_resp_long = long_q;
        o_crc_err   = crcErr_q;
        o_frame_err = frameErr_q;
        o_timeout   = timeout_q;
    end

endmodule

// File: tb/tb_sdio_rx.sv
// ---------------------------------------------------------------------------
// tb_sdio_rx
//
// Directed bench for sdio_rx. sdio_clk is derived from clk (divide by 8),
// the CMD line changes on falling sdio_clk edges, and each scenario task
// checks the parsed outputs against values built by the bench.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdio_rx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sdioClk;
    logic         sdio_cmd_i = 1'b1;
    logic         i_en = 1'b0;
    logic [1:0]   i_resp_type = 2'd0;
    logic         o_busy;
    logic         o_done;
    logic [5:0]   o_resp_idx;
    logic [31:0]  o_resp_arg;
    logic [126:0] o_resp_long;
    logic         o_crc_err;
    logic         o_frame_err;
    logic         o_timeout;

    logic [2:0]   divCnt = 3'd0;
    logic         prevSdio = 1'b0;
    logic [126:0] r2Payload;
    int           checks = 0;
    int           failures = 0;
    int           doneCount = 0;
    int           doneBase = 0;

    sdio_rx #(.TIMEOUT_CYC(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sdio_clk    (sdioClk),
        .sdio_cmd_i  (sdio_cmd_i),
        .i_en        (i_en),
        .i_resp_type (i_resp_type),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_resp_idx  (o_resp_idx),
        .o_resp_arg  (o_resp_arg),
        .o_resp_long (o_resp_long),
        .o_crc_err   (o_crc_err),
        .o_frame_err (o_frame_err),
        .o_timeout   (o_timeout)
    );

    // System clock, 10 ns period.
    always #5 clk = ~clk;

    // Divided SD clock: four clk cycles low, four high.
    always @(posedge clk) divCnt <= divCnt + 3'd1;
    assign sdioClk = divCnt[2];

    // Count every done pulse so scenarios can check for exactly one.
    always @(negedge clk) if (o_done === 1'b1) doneCount++;

    // Reference CRC7, generator x^7 + x^3 + 1, initial value 0.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // 48-bit response frame with a correct CRC, right-aligned in 136 bits.
    function automatic logic [135:0] shortFrame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b00, idx, arg};
        return {88'd0, head, crc7(head), 1'b1};
    endfunction

    // Arm the receiver; called at a falling clk edge, returns one cycle later.
    task automatic armDut(input logic [1:0] t);
        i_en        = 1'b1;
        i_resp_type = t;
        doneBase    = doneCount;
        prevSdio    = sdioClk;
        @(negedge clk);
        i_en = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL arm_busy got=%b exp=1", o_busy);
        end
    endtask

    // Drive idle-high bits, then frame bits f[hi] down to f[lo].
    task automatic sendBits(input logic [135:0] f, input int hi, input int lo, input int idle);
        for (int i = 0; i < idle; i++) begin
            @(negedge sdioClk);
            sdio_cmd_i = 1'b1;
        end
        for (int i = hi; i >= lo; i--) begin
            @(negedge sdioClk);
            sdio_cmd_i = f[i];
        end
    endtask

    // Wait (bounded) until the receiver is idle again.
    task automatic waitIdle;
        int n;
        n = 0;
        @(negedge clk);
        while (o_busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wait_idle got_busy=%b exp=0 after %0d cycles", o_busy, n);
        end
    endtask

    task automatic finishFrame;
        @(negedge sdioClk);
        sdio_cmd_i = 1'b1;
        waitIdle();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_crc_err, o_frame_err, o_timeout} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=00000",
                     {o_busy, o_done, o_crc_err, o_frame_err, o_timeout});
        end
        checks++;
        if ({o_resp_idx, o_resp_arg, o_resp_long} !== 165'd0) begin
            failures++;
            $display("[TB] FAIL reset_data got idx=%h arg=%h long=%h exp=0",
                     o_resp_idx, o_resp_arg, o_resp_long);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_r1;
        logic [135:0] f;
        f = shortFrame(6'd17, 32'h0000_0900);
        @(negedge clk);
        armDut(2'd0);
        sendBits(f, 47, 0, 5);
        finishFrame();
        checks++;
        if (o_resp_idx !== 6'd17) begin
            failures++;
            $display("[TB] FAIL r1_idx got=%0d exp=17", o_resp_idx);
        end
        checks++;
        if (o_resp_arg !== 32'h0000_0900) begin
            failures++;
            $display("[TB] FAIL r1_arg got=%h exp=00000900", o_resp_arg);
        end
        checks++;
        if ({o_crc_err, o_frame_err, o_timeout} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL r1_errors got=%b exp=000", {o_crc_err, o_frame_err, o_timeout});
        end
        checks++;
        if (doneCount - doneBase != 1) begin
            failures++;
            $display("[TB] FAIL r1_done_count got=%0d exp=1", doneCount - doneBase);
        end
    endtask

    task automatic test_crc_err;
        logic [135:0] f;
        f = shortFrame(6'd17, 32'h0000_0900) ^ 136'h2;
        @(negedge clk);
        armDut(2'd0);
        sendBits(f, 47, 0, 5);
        finishFrame();
        checks++;
        if ({o_crc_err, o_frame_err} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL crc_flags got crc=%b frame=%b exp crc=1 frame=0", o_crc_err, o_frame_err);
        end
        checks++;
        if ({o_resp_idx, o_resp_arg} !== {6'd17, 32'h0000_0900}) begin
            failures++;
            $display("[TB] FAIL crc_data got idx=%h arg=%h exp idx=11 arg=00000900", o_resp_idx, o_resp_arg);
        end
    endtask

    task automatic test_r3;
        logic [135:0] f;
        f = {88'd0, 2'b00, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1};
        @(negedge clk);
        armDut(2'd2);
        sendBits(f, 47, 0, 5);
        finishFrame();
        checks++;
        if ({o_resp_idx, o_resp_arg} !== {6'h3F, 32'h80FF_8000}) begin
            failures++;
            $display("[TB] FAIL r3_data got idx=%h arg=%h exp idx=3f arg=80ff8000", o_resp_idx, o_resp_arg);
        end
        checks++;
        if ({o_crc_err, o_frame_err, o_timeout} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL r3_errors got=%b exp=000", {o_crc_err, o_frame_err, o_timeout});
        end
    endtask

    task automatic test_r2;
        logic [127:0] p128;
        logic [135:0] f;
        p128      = {16{8'hAA}};
        r2Payload = p128[127:1];
        f         = {2'b00, 6'h3F, r2Payload, 1'b1};
        @(negedge clk);
        armDut(2'd1);
        sendBits(f, 135, 0, 5);
        finishFrame();
        checks++;
        if (o_resp_long !== r2Payload) begin
            failures++;
            $display("[TB] FAIL r2_long got=%h exp=%h", o_resp_long, r2Payload);
        end
        checks++;
        if ({o_resp_idx, o_resp_arg} !== {6'h3F, 32'h80FF_8000}) begin
            failures++;
            $display("[TB] FAIL r2_keep_short got idx=%h arg=%h exp idx=3f arg=80ff8000", o_resp_idx, o_resp_arg);
        end
        checks++;
        if ({o_crc_err, o_frame_err} !== 2'b00 || doneCount - doneBase != 1) begin
            failures++;
            $display("[TB] FAIL r2_status got crc=%b frame=%b dones=%0d exp 0 0 1",
                     o_crc_err, o_frame_err, doneCount - doneBase);
        end
    endtask

    task automatic test_timeout;
        int strobes;
        int since;
        bit seen;
        sdio_cmd_i = 1'b1;
        @(negedge clk);
        armDut(2'd0);
        strobes = 0;
        since   = 0;
        seen    = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (o_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (sdioClk && !prevSdio) begin
                    strobes++;
                    since = 0;
                end else begin
                    since++;
                end
                prevSdio = sdioClk;
                @(negedge clk);
            end
        end
        checks++;
        if (!seen || strobes != 8 || since != 0) begin
            failures++;
            $display("[TB] FAIL timeout_timing got seen=%0d strobes=%0d cycles_after=%0d exp 1 8 0",
                     seen, strobes, since);
        end
        checks++;
        if ({o_timeout, o_crc_err, o_frame_err} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL timeout_flags got=%b exp=100", {o_timeout, o_crc_err, o_frame_err});
        end
        checks++;
        if ({o_resp_idx, o_resp_arg} !== {6'h3F, 32'h80FF_8000} || o_resp_long !== r2Payload) begin
            failures++;
            $display("[TB] FAIL timeout_data got idx=%h arg=%h long=%h exp unchanged",
                     o_resp_idx, o_resp_arg, o_resp_long);
        end
        waitIdle();
    endtask

    task automatic test_frame_err;
        logic [135:0] f;
        f    = shortFrame(6'd5, 32'h1234_5678);
        f[0] = 1'b0;
        @(negedge clk);
        armDut(2'd0);
        sendBits(f, 47, 0, 5);
        finishFrame();
        checks++;
        if ({o_frame_err, o_crc_err, o_timeout} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL frame_flags got frame=%b crc=%b timeout=%b exp 1 0 0",
                     o_frame_err, o_crc_err, o_timeout);
        end
        checks++;
        if ({o_resp_idx, o_resp_arg} !== {6'd5, 32'h1234_5678}) begin
            failures++;
            $display("[TB] FAIL frame_data got idx=%h arg=%h exp idx=05 arg=12345678", o_resp_idx, o_resp_arg);
        end
    endtask

    task automatic test_reset_midframe;
        logic [135:0] f;
        f = shortFrame(6'd9, 32'hCAFE_0001);
        @(negedge clk);
        armDut(2'd0);
        sendBits(f, 47, 28, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_crc_err, o_frame_err, o_timeout} !== 5'b0 ||
            {o_resp_idx, o_resp_arg, o_resp_long} !== 165'd0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got busy=%b idx=%h arg=%h frame=%b long=%h exp all 0",
                     o_busy, o_resp_idx, o_resp_arg, o_frame_err, o_resp_long);
        end
        repeat (3) @(negedge clk);
        rst_n      = 1'b1;
        sdio_cmd_i = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (doneCount != doneBase || o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_no_done got dones=%0d busy=%b exp 0 0", doneCount - doneBase, o_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [135:0] f;
        int n;
        f = shortFrame(6'h2A, 32'hDEAD_BEEF);
        @(negedge clk);
        armDut(2'd3);
        sendBits(f, 47, 20, 5);
        @(negedge clk);
        i_en        = 1'b1;
        i_resp_type = 2'd1;
        @(negedge clk);
        i_en = 1'b0;
        sendBits(f, 19, 0, 0);
        n = 0;
        while (o_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_done got=%b exp=1", o_done);
        end
        checks++;
        if ({o_resp_idx, o_resp_arg, o_crc_err, o_frame_err} !== {6'h2A, 32'hDEAD_BEEF, 2'b00}) begin
            failures++;
            $display("[TB] FAIL b2b_first got idx=%h arg=%h crc=%b frame=%b exp idx=2a arg=deadbeef 0 0",
                     o_resp_idx, o_resp_arg, o_crc_err, o_frame_err);
        end
        @(negedge clk);
        armDut(2'd2);
        f = shortFrame(6'h01, 32'h0000_00FF);
        sendBits(f, 47, 0, 5);
        finishFrame();
        checks++;
        if ({o_resp_idx, o_resp_arg, o_crc_err} !== {6'h01, 32'h0000_00FF, 1'b0}) begin
            failures++;
            $display("[TB] FAIL b2b_rearm got idx=%h arg=%h crc=%b exp idx=01 arg=000000ff 0",
                     o_resp_idx, o_resp_arg, o_crc_err);
        end
        checks++;
        if (doneCount - doneBase != 1) begin
            failures++;
            $display("[TB] FAIL b2b_done_count got=%0d exp=1", doneCount - doneBase);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_r1();
        test_crc_err();
        test_r3();
        test_r2();
        test_timeout();
        test_frame_err();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

endmodule
